// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures an incoming PWM waveform and reports its period,
// its high time and its duty cycle in 0..DUTY_STEP units. A restoring divider
// converts high_time*DUTY_STEP/period into a quotient, one bit per clock.
// If no rising edge arrives for TIMEOUT_CYCLES clocks, the input is treated
// as static.
module pwm_duty_decoder #(
    parameter int unsigned DUTY_STEP      = 200,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic        pwm_in,
    output logic [31:0] duty,
    output logic [31:0] period_cnt,
    output logic [31:0] high_cnt,
    output logic        valid,
    output logic        timeout
);

    localparam logic [31:0] DUTY_W = 32'(DUTY_STEP);
    localparam logic [31:0] TMO_W  = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DIV   = 2'd2
    } state_t;

    // Input synchronizer and edge-detect delay stage
    logic        s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic        pedge_s;

    // Free-running measurement counters
    logic [31:0] cnt_period_q, cnt_period_d;
    logic [31:0] cnt_high_q, cnt_high_d;

    // Capture, divider and FSM state
    state_t      state_q, state_d;
    logic [31:0] cap_p_q, cap_p_d;
    logic [31:0] cap_h_q, cap_h_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  iter_q, iter_d;

    // Registered outputs
    logic [31:0] duty_q, duty_d;
    logic [31:0] period_q, period_d;
    logic [31:0] high_q, high_d;
    logic        valid_q, valid_d;
    logic        timeout_q, timeout_d;

    // Divider datapath and control helpers
    logic [31:0] rem_shift_lo_s;
    logic        rem_ge_s;
    logic [31:0] rem_next_s;
    logic [31:0] quo_next_s;
    logic        timed_out_s;
    logic        tmo_hit_s;
    logic [31:0] static_duty_s;
    logic [31:0] dividend_s;

    // Synchronize pwm_in, detect rising edges, and run the period/high counters
    always_comb begin
        s1_d    = pwm_in;
        s2_d    = s1_q;
        s3_d    = s2_q;
        pedge_s = s2_q & ~s3_q;

        if (pedge_s) begin
            cnt_period_d = 32'd1;
            cnt_high_d   = 32'd1;
        end else begin
            if (cnt_period_q < TMO_W) begin
                cnt_period_d = cnt_period_q + 32'd1;
            end else begin
                cnt_period_d = cnt_period_q;
            end
            if (s2_q && (cnt_high_q < TMO_W)) begin
                cnt_high_d = cnt_high_q + 32'd1;
            end else begin
                cnt_high_d = cnt_high_q;
            end
        end
    end

    // Perform one restoring-division step. The partial remainder is always below
    // the divisor, so its 33rd bit is just rem_q[31] after the shift.
    always_comb begin
        rem_shift_lo_s = {rem_q[30:0], quo_q[31]};
        rem_ge_s       = rem_q[31] | (rem_shift_lo_s >= cap_p_q);
        if (rem_ge_s) begin
            rem_next_s = rem_shift_lo_s - cap_p_q;
        end else begin
            rem_next_s = rem_shift_lo_s;
        end
        quo_next_s = {quo_q[30:0], rem_ge_s};
    end

    // Run the FSM: arm, capture, divide, publish results and handle timeouts
    always_comb begin
        state_d   = state_q;
        cap_p_d   = cap_p_q;
        cap_h_d   = cap_h_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        iter_d    = iter_q;
        duty_d    = duty_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        // The high time stays below 2^24 and DUTY_STEP stays below 256, so the
        // product is exact in 32 bits.
        dividend_s    = cnt_high_q * DUTY_W;
        static_duty_s = s2_q ? DUTY_W : 32'd0;
        timed_out_s   = (state_q == ST_IDLE) && timeout_q;
        tmo_hit_s     = (cnt_period_q == TMO_W) && !pedge_s && !timed_out_s;

        case (state_q)
            ST_IDLE: begin
                if (pedge_s) begin
                    // The first edge only starts the counters. A rising line
                    // that was static still reports its new level.
                    state_d = ST_ARMED;
                    if (timed_out_s) begin
                        duty_d  = DUTY_W;
                        valid_d = 1'b1;
                    end else begin
                        valid_d = 1'b0;
                    end
                end else if (tmo_hit_s) begin
                    duty_d    = static_duty_s;
                    period_d  = 32'd0;
                    high_d    = 32'd0;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else if (timed_out_s && (s2_q != s3_q)) begin
                    duty_d  = static_duty_s;
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (pedge_s) begin
                    cap_p_d = cnt_period_q;
                    cap_h_d = cnt_high_q;
                    quo_d   = dividend_s;
                    rem_d   = 32'd0;
                    iter_d  = 6'd0;
                    state_d = ST_DIV;
                end else if (tmo_hit_s) begin
                    state_d   = ST_IDLE;
                    duty_d    = static_duty_s;
                    period_d  = 32'd0;
                    high_d    = 32'd0;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_DIV: begin
                // Edges arriving here reload the counters but are not captured.
                if (iter_q == 6'd32) begin
                    duty_d    = quo_q;
                    period_d  = cap_p_q;
                    high_d    = cap_h_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    state_d   = ST_ARMED;
                end else begin
                    rem_d  = rem_next_s;
                    quo_d  = quo_next_s;
                    iter_d = iter_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset_p
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            cnt_period_q <= 32'd0;
            cnt_high_q   <= 32'd0;
            state_q      <= ST_IDLE;
            cap_p_q      <= 32'd0;
            cap_h_q      <= 32'd0;
            rem_q        <= 32'd0;
            quo_q        <= 32'd0;
            iter_q       <= 6'd0;
            duty_q       <= 32'd0;
            period_q     <= 32'd0;
            high_q       <= 32'd0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            cnt_period_q <= cnt_period_d;
            cnt_high_q   <= cnt_high_d;
            state_q      <= state_d;
            cap_p_q      <= cap_p_d;
            cap_h_q      <= cap_h_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            iter_q       <= iter_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            high_q       <= high_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign duty       = duty_q;
    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder. A reference model predicts every
// measurement from the drawn waveform: the duty comes from plain arithmetic,
// and an edge is dropped when it falls within 34 clocks of the previous
// capture.
module tb_pwm_duty_decoder;

    localparam int DUTY = 200;
    localparam int TMO  = 20000;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic        pwm_in = 1'b0;
    logic [31:0] duty, period_cnt, high_cnt;
    logic        valid, timeout;

    always #5 clk = ~clk;

    pwm_duty_decoder #(.DUTY_STEP(DUTY), .TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset_p    (reset_p),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period_cnt (period_cnt),
        .high_cnt   (high_cnt),
        .valid      (valid),
        .timeout    (timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] duty;
        logic [31:0] per;
        logic [31:0] hi;
        logic        tmo;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];

    // Log every valid pulse, sampled away from the active edge
    always @(negedge clk) begin
        if (valid) obs_q.push_back('{cyc, duty, period_cnt, high_cnt, timeout});
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    endtask

    // Reference model state
    bit have_prev = 1'b0;
    int tcap = 0;
    int last_p = 0;
    int last_h = 0;

    // Account for a rising edge driven now, which starts a period (p, h)
    task automatic model_edge(input int p, input int h);
        rec_t r;
        if (have_prev) begin
            if (cyc - tcap >= 34) begin
                r.cyc  = cyc + 36;
                r.duty = 32'((longint'(last_h) * DUTY) / last_p);
                r.per  = 32'(last_p);
                r.hi   = 32'(last_h);
                r.tmo  = 1'b0;
                exp_q.push_back(r);
                tcap = cyc;
            end
        end else begin
            have_prev = 1'b1;
            tcap = cyc - 1000;
        end
        last_p = p;
        last_h = h;
    endtask

    task automatic pulse(input int p, input int h);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    task automatic edge_pulse(input int p, input int h);
        model_edge(p, h);
        pulse(p, h);
    endtask

    task automatic compare_results(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_duty"}, obs_q[i].duty, exp_q[i].duty);
            check({tag, "_period"}, obs_q[i].per, exp_q[i].per);
            check({tag, "_high"}, obs_q[i].hi, exp_q[i].hi);
            check({tag, "_timeout"}, 32'(obs_q[i].tmo), 32'(exp_q[i].tmo));
            check({tag, "_cycle"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    int p, h, t_edge;
    bit in_window;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_duty", duty, 32'd0);
        check("rst_period", period_cnt, 32'd0);
        check("rst_high", high_cnt, 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        reset_p = 1'b0;
        @(negedge clk);

        // 10 kHz at 25 %, then hold the line high until timeout
        edge_pulse(10000, 2500);
        edge_pulse(10000, 2500);
        t_edge = cyc;
        model_edge(10000, 2500);
        pwm_in = 1'b1;
        repeat (100) @(negedge clk);
        compare_results("p10k");
        repeat (TMO) @(negedge clk);
        check("tmo_hi_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            check("tmo_hi_duty", obs_q[0].duty, 32'(DUTY));
            check("tmo_hi_period", obs_q[0].per, 32'd0);
            check("tmo_hi_high", obs_q[0].hi, 32'd0);
            check("tmo_hi_flag", 32'(obs_q[0].tmo), 32'd1);
            in_window = (obs_q[0].cyc - t_edge >= TMO) && (obs_q[0].cyc - t_edge <= TMO + 6);
            check("tmo_hi_latency", 32'(in_window), 32'd1);
        end else begin
            check("tmo_hi_missing", 32'(obs_q.size()), 32'd1);
        end
        check("tmo_level", 32'(timeout), 32'd1);
        obs_q.delete();
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        check("tmo_lo_count", 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            check("tmo_lo_duty", obs_q[0].duty, 32'd0);
            check("tmo_lo_period", obs_q[0].per, 32'd0);
            check("tmo_lo_flag", 32'(obs_q[0].tmo), 32'd1);
        end else begin
            check("tmo_lo_missing", 32'(obs_q.size()), 32'd1);
        end
        obs_q.delete();

        // Reset, then randomized periods plus a duty=37 loopback case
        @(negedge clk);
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        reset_p = 1'b0;
        have_prev = 1'b0;
        edge_pulse(300, 100);
        for (int i = 0; i < 12; i++) begin
            p = int'($urandom_range(300, 40));
            h = int'($urandom_range(p - 1, 1));
            edge_pulse(p, h);
        end
        edge_pulse(400, 74);
        edge_pulse(400, 74);
        edge_pulse(100, 50);
        compare_results("rand");

        // Short period: edges landing during division are dropped
        for (int i = 0; i < 9; i++) edge_pulse(20, 5);
        edge_pulse(100, 50);
        compare_results("short");

        // Reset in the middle of a division
        edge_pulse(60, 20);
        compare_results("pre_rst");
        pwm_in = 1'b1;
        repeat (15) @(negedge clk);
        reset_p = 1'b1;
        #1;
        check("mid_rst_duty", duty, 32'd0);
        check("mid_rst_period", period_cnt, 32'd0);
        check("mid_rst_high", high_cnt, 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid_hold", 32'(valid), 32'd0);
        reset_p = 1'b0;
        have_prev = 1'b0;
        repeat (50) @(negedge clk);
        check("mid_rst_no_valid", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        edge_pulse(80, 40);
        edge_pulse(80, 20);
        edge_pulse(80, 60);
        edge_pulse(100, 50);
        compare_results("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_duty_decoder.md
# pwm_duty_decoder

Receive-side counterpart of `pwm_Nfreq_Nstep`. It measures an incoming PWM waveform and reports its period and high time in system clocks. It also reports the duty cycle in the same 0..DUTY_STEP step units that the generator accepts on its `duty` input. It sits between an external PWM or servo-feedback pin and user logic, for example to drive `FND_cntr` or a loopback check against the generator.

## Interface
Parameters:
- `DUTY_STEP`, 200: full-scale duty value, in the same units as the generator. Range 1..255.
- `TIMEOUT_CYCLES`, 1_000_000: number of clocks without a rising edge before the input is declared static. Range 64..2^24.

Ports:
- `clk` input, 1 bit: system clock, 100 MHz nominal.
- `reset_p` input, 1 bit: asynchronous, active-high reset.
- `pwm_in` input, 1 bit: asynchronous PWM input.
- `duty` output, 32 bits: measured duty, equal to floor(high_cnt*DUTY_STEP/period_cnt).
- `period_cnt` output, 32 bits: last measured period, in clocks.
- `high_cnt` output, 32 bits: last measured high time, in clocks.
- `valid` output, 1 bit: single-cycle pulse when the outputs update.
- `timeout` output, 1 bit: level. High while the input is static and no measurement is current.

## Operation
- Input conditioning:
  - `pwm_in` passes through a 2-FF synchronizer (`s1`, `s2`) and then one delay FF (`s3`). All reset to 0.
  - `pedge = s2 & ~s3`.
- Measurement counters (32-bit, reset 0):
  - On `pedge`: `cnt_period <= 1` and `cnt_high <= 1`.
  - Otherwise: `cnt_period` increments and saturates at TIMEOUT_CYCLES. `cnt_high` increments while `s2 = 1`.
  - Result: at the next `pedge`, `cnt_period` equals the exact period P and `cnt_high` equals the exact high time H.
- FSM states:
  - IDLE: reset state, not armed.
  - ARMED: a rising edge has been seen and a measurement is in progress.
  - DIV: sequential division.
- FSM transitions:
  - IDLE → ARMED on `pedge`. No capture happens, because the first edge only starts the counters.
  - ARMED → DIV on `pedge`:
    - latch `cap_p = cnt_period` and `cap_h = cnt_high`;
    - load the dividend as `cap_h*DUTY_STEP`, which is 32 bits and exact under the parameter ranges;
    - clear the iteration counter.
  - DIV: restoring divider with a 32-bit quotient, one bit per clock, exactly 32 iterations. Divisor `cap_p` is always ≥ 2, so division by zero cannot occur.
  - DIV → ARMED after the 32nd iteration. That cycle registers `duty` (the quotient), `period_cnt = cap_p`, `high_cnt = cap_h`, `valid = 1` and `timeout = 0`.
- `pedge` during DIV:
  - The counters still reload, so the next period is measured correctly.
  - No new capture is made; that period's result is dropped.
  - The division continues unaffected. Periods ≥ 40 clocks therefore never drop results.
- Timeout:
  - Trigger: in ARMED or IDLE, `cnt_period` reaches TIMEOUT_CYCLES.
  - In that cycle:
    - go to IDLE;
    - `duty` = DUTY_STEP if `s2 = 1`, else 0;
    - `period_cnt = 0` and `high_cnt = 0`;
    - `valid` pulses and `timeout` goes to 1;
    - the counters hold at saturation.
  - While already timed out, the counter stays saturated with no further `valid` pulses, with one exception: if the line level changes, `duty` updates to the new static value and `valid` pulses.
  - The first `pedge` after a timeout re-arms the block. `timeout` clears only at the next completed division.
- Width and arithmetic:
  - `duty` ≤ DUTY_STEP always, because H ≤ P−1.
  - All counters are unsigned and never wrap, because they saturate.
- Reset mid-operation (including in DIV): every register returns to its reset value immediately and no `valid` is emitted.

## Timing
- Reset values:
  - `duty`, `period_cnt`, `high_cnt` = 0;
  - `valid` = 0;
  - `timeout` = 0;
  - state = IDLE.
- Latency: let N be the first clock edge that samples `pwm_in = 1` into `s1`.
  - `pedge` is high from edge N+1 to edge N+2.
  - The capture happens at edge N+2.
  - Division iterations run at edges N+3 through N+34.
  - Outputs update and `valid` = 1 from edge N+35 to edge N+36.
- `valid` is high for exactly one clock per update. The outputs hold their values until the next update.
- Timeout is declared TIMEOUT_CYCLES clocks after the last `pedge`. If no edge has occurred since reset, it is declared TIMEOUT_CYCLES clocks after reset release.

## Test plan
- 10 kHz PWM (P=10000, H=2500), DUTY_STEP=200: the first `valid` comes after the second rising edge, with `period_cnt`=10000, `high_cnt`=2500, `duty`=50. `valid` then repeats every 10000 clocks.
- Loopback from `pwm_Nfreq_Nstep` with duty=37, 10 kHz, 200 steps: `duty`=37 and `period_cnt`=10000 on every update.
- Latency check: drive `pwm_in` high, aligned so the first edge sampling it is N. `valid` must be high exactly during the cycle after edge N+35, and `timeout` must be 0.
- Timeout with TIMEOUT_CYCLES=20000: lock to P=10000, then hold `pwm_in` high. After 20000 clocks with no edge: `duty`=200, `period_cnt`=0, `timeout`=1, one `valid`. Then drive the line low: one `valid` with `duty`=0.
- Short period P=20, H=5: every other rising edge falls during DIV and is dropped. Each reported result is `duty`=50, `period_cnt`=20, and no result is corrupted.
- Assert `reset_p` midway through DIV: all outputs are 0 immediately, no `valid` appears, and measurement resumes correctly on subsequent edges.
